// File: rtl/fp_sgf_normalizer_pkg.sv
// fp_sgf_normalizer_pkg: shared state encodings and format width constants for the normalizer
package fp_sgf_normalizer_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   localparam int W_SGF_SP = 23;
   localparam int W_EXP_SP = 8;
   localparam int W_SGF_DP = 52;
   localparam int W_EXP_DP = 11;
endpackage

// File: rtl/fp_norm_shifter.sv
// fp_norm_shifter: significand register with load, shift-left and shift-right by one
//   clk   in  clock
//   rst   in  synchronous active-low reset, clears the register
//   load  in  capture d (highest priority)
//   shr   in  shift right one, 0 into MSB
//   shl   in  shift left one, 0 into LSB
//   d     in  [W-1:0] value to load
//   q     out [W-1:0] current register contents
// Build option: STICKY_EN folds the bit shifted out on a right shift into bit 0.
module fp_norm_shifter #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shr,
   input  logic         shl,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] sr_q;
   always_ff @(posedge clk) begin
      if (!rst) sr_q <= '0;
      else if (load) sr_q <= d;
`ifdef STICKY_EN
      else if (shr) sr_q <= {1'b0, sr_q[W-1:2], sr_q[1] | sr_q[0]};
`else
      else if (shr) sr_q <= {1'b0, sr_q[W-1:1]};
`endif
      else if (shl) sr_q <= {sr_q[W-2:0], 1'b0};
   end
   assign q = sr_q;
endmodule

// File: rtl/fp_sgf_normalizer.sv
// fp_sgf_normalizer: self-sequenced significand normalizer with exponent tracking and handshake
//   clk        in   clock
//   rst        in   synchronous active-low reset
//   in_valid   in   operand valid
//   in_ready   out  idle, operand can be accepted
//   sgf_in     in   [W_SGF+3:0] raw sum, bit W_SGF+3 carry, bit W_SGF+2 leading bit
//   exp_in     in   [W_EXP-1:0] biased exponent before normalization
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   sgf_out    out  [W_SGF+2:0] normalized significand
//   exp_out    out  [W_EXP-1:0] adjusted biased exponent
//   zero_flag  out  significand was zero
//   ovf_flag   out  exponent reached all-ones
//   unf_flag   out  stopped at minimum exponent (denormal)
// Build option: STICKY_EN (passed to fp_norm_shifter) keeps a sticky bit on right shifts.
module fp_sgf_normalizer
   import fp_sgf_normalizer_pkg::*;
#(
   parameter int W_SGF = W_SGF_SP,
   parameter int W_EXP = W_EXP_SP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_SGF+3:0] sgf_in,
   input  logic [W_EXP-1:0] exp_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_SGF+2:0] sgf_out,
   output logic [W_EXP-1:0] exp_out,
   output logic             zero_flag,
   output logic             ovf_flag,
   output logic             unf_flag
);
   localparam int W = W_SGF + 4;
   localparam logic [W_EXP-1:0] EXP_MAX = '1;
   state_t           state_q;
   logic [W_EXP-1:0] er_q, er_inc, exp_q;
   logic [W-1:0]     sr;
   logic [W-2:0]     sgf_q;
   logic             in_ready_q, out_valid_q, zero_q, ovf_q, unf_q;
   logic             in_norm, load, shl, shr, is_zero, has_carry, has_lead, can_shl;
   assign is_zero   = sr == '0;
   assign has_carry = sr[W-1];
   assign has_lead  = sr[W-2];
   assign can_shl   = er_q > W_EXP'(1);
   assign er_inc    = er_q + W_EXP'(1);
   assign in_norm   = state_q == ST_NORM;
   assign load      = state_q == ST_IDLE && in_valid;
   assign shr       = in_norm && !is_zero && has_carry;
   assign shl       = in_norm && !is_zero && !has_carry && !has_lead && can_shl;
   fp_norm_shifter #(.W(W)) u_shifter (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shr  (shr),
      .shl  (shl),
      .d    (sgf_in),
      .q    (sr)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         er_q        <= '0;
         sgf_q       <= '0;
         exp_q       <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) begin
               er_q       <= exp_in;
               in_ready_q <= 1'b0;
               state_q    <= ST_NORM;
            end
            ST_NORM: begin
               if (is_zero) begin
                  sgf_q   <= '0;
                  exp_q   <= '0;
                  zero_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (has_carry) begin
                  er_q <= er_inc;
                  // stop before the exponent could wrap past infinity
                  if (er_inc == EXP_MAX) begin
                     sgf_q   <= '0;
                     exp_q   <= EXP_MAX;
                     ovf_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end else if (has_lead) begin
                  sgf_q   <= sr[W-2:0];
                  exp_q   <= er_q;
                  state_q <= ST_DONE;
               end else if (can_shl) begin
                  er_q <= er_q - W_EXP'(1);
               end else begin
                  sgf_q   <= sr[W-2:0];
                  exp_q   <= '0;
                  unf_q   <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            // result registers settle on entry; out_valid follows one edge later
            ST_DONE: if (!out_valid_q) out_valid_q <= 1'b1;
               else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  zero_q      <= 1'b0;
                  ovf_q       <= 1'b0;
                  unf_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sgf_out   = sgf_q;
   assign exp_out   = exp_q;
   assign zero_flag = zero_q;
   assign ovf_flag  = ovf_q;
   assign unf_flag  = unf_q;
endmodule

// File: tb/tb_fp_sgf_normalizer.sv
// tb_fp_sgf_normalizer: scoreboard bench with a behavioural normalization model
module tb_fp_sgf_normalizer;
   typedef struct {
      logic [25:0] sgf;
      logic [7:0]  ex;
      logic        z, o, u;
      int          lat;
      int          due;
   } res_t;
   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic        zero_flag, ovf_flag, unf_flag;
   logic [26:0] sgf_in;
   logic [7:0]  exp_in, exp_out;
   logic [25:0] sgf_out;
   int          checks = 0, errors = 0, cyc = 0;
   bit          force_low = 0;
   res_t        sb[$];
   res_t        mon_e;
   logic        pv, pr;
   logic [36:0] snap, cur;
   fp_sgf_normalizer #(.W_SGF(23), .W_EXP(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sgf_in    (sgf_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sgf_out   (sgf_out),
      .exp_out   (exp_out),
      .zero_flag (zero_flag),
      .ovf_flag  (ovf_flag),
      .unf_flag  (unf_flag)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      out_ready = 0;
      forever begin
         @(posedge clk);
         #1 out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end
   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask
   // Normalization from first principles: locate the leading one, count the
   // shifts needed and the shifts the exponent can afford.
   function automatic res_t model(logic [26:0] s, logic [7:0] e);
      res_t r;
      logic [7:0]  e1;
      logic [26:0] t;
      int p, need, allow, n;
      r.sgf = '0; r.ex = '0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2; r.due = 0;
      e1 = e + 8'd1;
      if (s == 0) r.z = 1;
      else if (s[26]) begin
         if (e1 == 8'hff) begin
            r.o = 1;
            r.ex = 8'hff;
         end else begin
            t = s >> 1;
`ifdef STICKY_EN
            t[0] = t[0] | s[0];
`endif
            r.sgf = t[25:0];
            r.ex = e1;
            r.lat = 3;
         end
      end else begin
         p = 0;
         for (int i = 0; i < 27; i++) if (s[i]) p = i;
         need = 25 - p;
         allow = (e > 1) ? int'(e) - 1 : 0;
         n = (need < allow) ? need : allow;
         t = s << n;
         r.sgf = t[25:0];
         r.lat = n + 2;
         if (need <= allow) r.ex = e - 8'(need);
         else r.u = 1;
      end
      return r;
   endfunction
   task automatic send(logic [26:0] s, logic [7:0] e);
      int n = 0;
      res_t x;
      sgf_in = s;
      exp_in = e;
      in_valid = 1;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      x = model(s, e);
      x.due = cyc + x.lat;
      sb.push_back(x);
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 0);
   endtask
   assign cur = {sgf_out, exp_out, zero_flag, ovf_flag, unf_flag};
   always @(negedge clk) begin
      if (!rst) begin
         pv <= 0;
         pr <= 0;
         snap <= '0;
      end else begin
         if (out_valid && !pv) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else chk("latency", 64'(cyc), 64'(sb[0].due));
            chk("in_ready_busy", {63'd0, in_ready}, 0);
         end
         if (out_valid && pv && !pr) begin
            chk("hold_stable", {27'd0, cur}, {27'd0, snap});
            chk("hold_in_ready", {63'd0, in_ready}, 0);
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("result", {27'd0, cur}, {27'd0, mon_e.sgf, mon_e.ex, mon_e.z, mon_e.o, mon_e.u});
         end
         pv <= out_valid;
         pr <= out_ready;
         snap <= cur;
      end
   end
   initial begin
      logic [26:0] s;
      logic [7:0]  e;
      int r, k, n;
      rst = 0;
      in_valid = 0;
      sgf_in = '0;
      exp_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 0);
      chk("rst_in_ready", {63'd0, in_ready}, 1);
      chk("rst_outputs", {27'd0, cur}, 0);
      rst = 1;
      @(negedge clk);
      send(27'h4000000, 8'd100);
      send(27'h2000000, 8'd100);
      send(27'h0000001, 8'd127);
      send(27'h0000000, 8'd55);
      send(27'h4000000, 8'd254);
      send(27'h0400000, 8'd2);
      send(27'h4000001, 8'd10);
      send(27'h0000003, 8'd0);
      send(27'h4000000, 8'd255);
      drain();
      force_low = 1;
      send(27'h1234567 >> 2, 8'd77);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reached_valid", {63'd0, out_valid}, 1);
      sgf_in = 27'h5555555;
      exp_in = 8'd3;
      in_valid = 1;
      repeat (5) @(negedge clk);
      in_valid = 0;
      force_low = 0;
      drain();
      repeat (150) begin
         r = $urandom_range(0, 9);
         s = 27'($urandom) >> $urandom_range(0, 26);
         if (r == 0) s = '0;
         k = $urandom_range(0, 2);
         e = (k == 0) ? 8'($urandom_range(0, 4)) : (k == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
         send(s, e);
      end
      drain();
      send(27'h0000001, 8'd127);
      repeat (4) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, out_valid}, 0);
      chk("midrst_in_ready", {63'd0, in_ready}, 1);
      chk("midrst_outputs", {27'd0, cur}, 0);
      void'(sb.pop_back());
      rst = 1;
      @(negedge clk);
      send(27'h0800000, 8'd40);
      drain();
      repeat (5) @(negedge clk);
      chk("no_extra_output", {63'd0, out_valid}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
